// File: rtl/des_pkg.sv
// Shared definitions for the DES controller: register map, FSM states
// and the per-round key-rotation schedules.
package des_pkg;

  localparam int NUM_ROUNDS = 16;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h04;
  localparam logic [4:0] OFF_KEY_HI  = 5'h08;
  localparam logic [4:0] OFF_KEY_LO  = 5'h0C;
  localparam logic [4:0] OFF_DIN_HI  = 5'h10;
  localparam logic [4:0] OFF_DIN_LO  = 5'h14;
  localparam logic [4:0] OFF_DOUT_HI = 5'h18;
  localparam logic [4:0] OFF_DOUT_LO = 5'h1C;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_CAPTURE} state_e;

  // Listed round 15 down to round 0. Decrypt starts from C16/D16 == C0/D0,
  // so its first round does not rotate.
  localparam logic [NUM_ROUNDS-1:0][1:0] ENC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
  localparam logic [NUM_ROUNDS-1:0][1:0] DEC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] rnd);
    return dec ? DEC_SHIFT[rnd] : ENC_SHIFT[rnd];
  endfunction

endpackage

// File: rtl/des_wb_regs.sv
// Wishbone slave for the DES controller: address decode, one-cycle ack,
// register file and registered read data.
module des_wb_regs
  import des_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic        i_busy,
  input  logic        i_capture,
  input  logic [63:0] i_dp_dout,
  output logic        o_start,
  output logic        o_decrypt,
  output logic        o_irq_en,
  output logic        o_done,
  output logic [63:0] o_key,
  output logic [63:0] o_din
);

  logic [31:0] offset, rdata, data_q, data_d;
  logic [2:0]  word;
  logic        in_range, req, wr;
  logic        ack_q, ack_d, decrypt_q, decrypt_d, irq_en_q, irq_en_d, done_q, done_d;
  logic [63:0] key_q, key_d, din_q, din_d, dout_q, dout_d;

  assign offset   = i_wb_addr - ADDR_BASE;
  assign in_range = offset < 32'd32;
  assign word     = offset[4:2];
  assign req      = i_wb_cyc && i_wb_stb && in_range && !ack_q;
  assign wr       = req && i_wb_we;
  assign o_start  = wr && word == OFF_CTRL[4:2] && i_wb_data[CTRL_START] && !i_busy;

  always_comb begin
    ack_d     = req;
    key_d     = key_q;
    din_d     = din_q;
    dout_d    = dout_q;
    decrypt_d = decrypt_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    rdata     = '0;
    case (word)
      OFF_CTRL[4:2]:    rdata = {29'd0, irq_en_q, decrypt_q, 1'b0};
      OFF_STATUS[4:2]:  rdata = {30'd0, done_q, i_busy};
      OFF_KEY_HI[4:2]:  rdata = key_q[63:32];
      OFF_KEY_LO[4:2]:  rdata = key_q[31:0];
      OFF_DIN_HI[4:2]:  rdata = din_q[63:32];
      OFF_DIN_LO[4:2]:  rdata = din_q[31:0];
      OFF_DOUT_HI[4:2]: rdata = dout_q[63:32];
      OFF_DOUT_LO[4:2]: rdata = dout_q[31:0];
      default:          rdata = '0;
    endcase
    data_d = (req && !i_wb_we) ? rdata : '0;
    // Operands and mode are frozen while the datapath is running.
    if (wr) begin
      case (word)
        OFF_CTRL[4:2]: if (!i_busy) begin
          decrypt_d = i_wb_data[CTRL_DECRYPT];
          irq_en_d  = i_wb_data[CTRL_IRQ_EN];
        end
        OFF_STATUS[4:2]: if (i_wb_data[STAT_DONE]) done_d = 1'b0;
        OFF_KEY_HI[4:2]: if (!i_busy) key_d[63:32] = i_wb_data;
        OFF_KEY_LO[4:2]: if (!i_busy) key_d[31:0]  = i_wb_data;
        OFF_DIN_HI[4:2]: if (!i_busy) din_d[63:32] = i_wb_data;
        OFF_DIN_LO[4:2]: if (!i_busy) din_d[31:0]  = i_wb_data;
        default: ;
      endcase
    end
    if (o_start) done_d = 1'b0;
    // Completion overrides a coincident clear.
    if (i_capture) begin
      dout_d = i_dp_dout;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      data_q    <= '0;
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      data_q    <= data_d;
      key_q     <= key_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      decrypt_q <= decrypt_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = data_q;
  assign o_decrypt = decrypt_q;
  assign o_irq_en  = irq_en_q;
  assign o_done    = done_q;
  assign o_key     = key_q;
  assign o_din     = din_q;

endmodule

// File: rtl/des_ctrl.sv
// Sequences the iterative DES datapath: load, 16 rounds with the key
// rotation schedule, capture; raises a level interrupt on completion.
module des_ctrl
  import des_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_dp_load,
  output logic        o_dp_en,
  output logic [3:0]  o_dp_round,
  output logic [1:0]  o_dp_shift,
  output logic        o_dp_decrypt,
  output logic [63:0] o_dp_key,
  output logic [63:0] o_dp_din,
  input  logic [63:0] i_dp_dout,
  output logic        o_irq
);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       busy, capture, start, decrypt, irq_en, done;

  assign busy    = state_q != ST_IDLE;
  assign capture = state_q == ST_CAPTURE;

  des_wb_regs #(.ADDR_BASE(ADDR_BASE)) u_regs (
    .clk       (clk),
    .reset     (reset),
    .i_wb_cyc  (i_wb_cyc),
    .i_wb_stb  (i_wb_stb),
    .i_wb_we   (i_wb_we),
    .i_wb_addr (i_wb_addr),
    .i_wb_data (i_wb_data),
    .o_wb_ack  (o_wb_ack),
    .o_wb_data (o_wb_data),
    .i_busy    (busy),
    .i_capture (capture),
    .i_dp_dout (i_dp_dout),
    .o_start   (start),
    .o_decrypt (decrypt),
    .o_irq_en  (irq_en),
    .o_done    (done),
    .o_key     (o_dp_key),
    .o_din     (o_dp_din)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Round counter wraps back to 0 after round 15, so it idles at 0.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  begin
        state_d = ST_ROUND;
        round_d = '0;
      end
      ST_ROUND: begin
        round_d = 4'(round_q + 4'd1);
        if (round_q == 4'(NUM_ROUNDS - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dp_load    = state_q == ST_LOAD;
    o_dp_en      = state_q == ST_ROUND;
    o_dp_round   = round_q;
    o_dp_shift   = o_dp_en ? shift_amt(decrypt, round_q) : 2'd0;
    o_dp_decrypt = decrypt;
    o_irq        = done && irq_en;
  end

endmodule

// File: tb/tb_des_ctrl.sv
// Directed + random bench for des_ctrl with a behavioural DES datapath and
// a textbook DES reference (standard subkey schedule, reversed for decrypt).
module tb_des_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0, reset;
  logic        cyc, stb, we, ack, dp_load, dp_en, dp_decrypt, irq;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  dp_round;
  logic [1:0]  dp_shift;
  logic [63:0] dp_key, dp_din, dp_dout;
  int          n_cmp = 0, n_bad = 0, load_cnt = 0;

  always #5 clk = ~clk;

  des_ctrl #(.ADDR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack), .o_wb_data(rdata),
    .o_dp_load(dp_load), .o_dp_en(dp_en), .o_dp_round(dp_round),
    .o_dp_shift(dp_shift), .o_dp_decrypt(dp_decrypt), .o_dp_key(dp_key),
    .o_dp_din(dp_din), .i_dp_dout(dp_dout), .o_irq(irq));

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28,
    35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
    24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
    30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  // Standard left-rotation count applied before each encryption subkey.
  localparam int KS_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction
  function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, y;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b = e[47-6*j -: 6];
      s[31-4*j -: 4] = 4'(SB[j][{b[5], b[0]} * 16 + b[4:1]]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction
  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction
  function automatic logic [27:0] ror28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

  // Reference: build K1..K16 by left rotation, apply them forward or reversed.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                          input logic dec);
    logic [47:0] ks [16];
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    cd = pc1(key);
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = rol28(c, KS_SH[i]);
      d = rol28(d, KS_SH[i]);
      ks[i] = pc2({c, d});
    end
    {l, r} = ip(blk);
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ ffun(r, dec ? ks[15-i] : ks[i]);
      l = t;
    end
    return fp({r, l});
  endfunction

  // Rotation a datapath must apply in round r so that it uses the right subkey.
  function automatic int exp_shift(input logic dec, input int r);
    if (!dec) return KS_SH[r];
    return (r == 0) ? 0 : KS_SH[16-r];
  endfunction

  // Behavioural round datapath driven by the controller outputs.
  logic [31:0] m_l, m_r;
  logic [27:0] m_c, m_d, c_nx, d_nx;
  assign c_nx    = dp_decrypt ? ror28(m_c, int'(dp_shift)) : rol28(m_c, int'(dp_shift));
  assign d_nx    = dp_decrypt ? ror28(m_d, int'(dp_shift)) : rol28(m_d, int'(dp_shift));
  assign dp_dout = fp({m_r, m_l});
  always @(posedge clk) begin
    if (dp_load) begin
      {m_l, m_r} <= ip(dp_din);
      {m_c, m_d} <= pc1(dp_key);
      load_cnt   <= load_cnt + 1;
    end else if (dp_en) begin
      m_c <= c_nx;
      m_d <= d_nx;
      m_l <= m_r;
      m_r <= m_l ^ ffun(m_r, pc2({c_nx, d_nx}));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    if (ack) tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    check("wr_ack", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    if (ack) tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    tick();
    check("rd_ack", 64'(ack), 64'd1);
    d = rdata;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_dpctl"}, 64'({dp_load, dp_en, dp_round, dp_shift, dp_decrypt, irq}), 64'd0);
    check({tag, "_key"}, dp_key, 64'd0);
    check({tag, "_din"}, dp_din, 64'd0);
  endtask

  task automatic load_operands(input logic [63:0] key, input logic [63:0] din);
    wb_write(BASE + 32'h08, key[63:32]);
    wb_write(BASE + 32'h0C, key[31:0]);
    wb_write(BASE + 32'h10, din[63:32]);
    wb_write(BASE + 32'h14, din[31:0]);
  endtask

  // One full block with cycle-exact checks; w1c issues a STATUS clear
  // in the CAPTURE cycle instead of a STATUS read.
  task automatic run_block(input logic [63:0] key, input logic [63:0] din, input logic dec,
                           input logic ien, input logic w1c, output logic [63:0] res);
    logic [31:0] st, hi, lo;
    load_operands(key, din);
    wb_write(BASE, {29'd0, ien, dec, 1'b1});
    check("load_pulse", 64'({dp_load, dp_en}), 64'b10);
    for (int r = 0; r < 16; r++) begin
      tick();
      check("round_en", 64'({dp_load, dp_en}), 64'b01);
      check("round_idx", 64'(dp_round), 64'(r));
      check("round_shift", 64'(dp_shift), 64'(exp_shift(dec, r)));
      check("round_dec", 64'(dp_decrypt), 64'(dec));
    end
    tick();
    check("capture_dp_idle", 64'({dp_load, dp_en, dp_shift}), 64'd0);
    check("irq_before_done", 64'(irq), 64'd0);
    cyc = 1'b1; stb = 1'b1; we = w1c; addr = BASE + 32'h04; wdata = 32'h2;
    tick();
    check("status_ack", 64'(ack), 64'd1);
    check("status_at_capture", 64'(rdata), w1c ? 64'd0 : 64'd1);
    check("irq_at_t19", 64'(irq), 64'(ien));
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_read(BASE + 32'h04, st);
    check("status_done", 64'(st), 64'd2);
    wb_read(BASE + 32'h18, hi);
    wb_read(BASE + 32'h1C, lo);
    res = {hi, lo};
    check("dout_ref", res, des_ref(key, din, dec));
    if (ien) begin
      wb_write(BASE + 32'h04, 32'h2);
      check("irq_cleared", 64'(irq), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] res, prev, k, d;
    logic [31:0] v;
    int          lc0, acks;
    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    run_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, res);
    check("kat_encrypt", res, 64'h85E813540F0AB405);
    run_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b0, 1'b0, res);
    check("kat_decrypt", res, 64'h0123456789ABCDEF);
    wb_read(BASE, v);
    check("ctrl_readback", 64'(v), 64'h2);

    run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, res);
    run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, prev);

    // Writes and a second start while busy must be acked and ignored.
    k = {$urandom, $urandom};
    d = {$urandom, $urandom};
    load_operands(k, d);
    lc0 = load_cnt;
    wb_write(BASE, 32'h1);
    tick();
    wb_write(BASE + 32'h0C, ~k[31:0]);
    wb_write(BASE, 32'h3);
    wb_read(BASE + 32'h18, v);
    check("dout_hi_while_busy", 64'(v), 64'(prev[63:32]));
    repeat (30) tick();
    check("single_completion", 64'(load_cnt - lc0), 64'd1);
    wb_read(BASE + 32'h0C, v);
    check("key_lo_stable", 64'(v), 64'(k[31:0]));
    wb_read(BASE, v);
    check("ctrl_busy_ignored", 64'(v), 64'd0);
    wb_read(BASE + 32'h18, v);
    wb_read(BASE + 32'h1C, res[31:0]);
    res[63:32] = v;
    check("busy_poke_dout", res, des_ref(k, d, 1'b0));

    // Out-of-window accesses are never acked.
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE + 32'h20;
    acks = 0;
    repeat (10) begin
      tick();
      if (ack) acks++;
    end
    we = 1'b1; addr = BASE - 32'h4; wdata = 32'h1;
    repeat (4) begin
      tick();
      if (ack) acks++;
    end
    check("out_of_range_acks", 64'(acks), 64'd0);
    check("out_of_range_no_start", 64'(load_cnt - lc0), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;

    wb_write(BASE + 32'h18, 32'hDEADBEEF);
    wb_read(BASE + 32'h18, v);
    check("dout_hi_readonly", 64'(v), 64'(res[63:32]));

    // Reset in the middle of round 7.
    load_operands(64'h0F1E2D3C4B5A6978, 64'h8877665544332211);
    wb_write(BASE, 32'h7);
    repeat (8) tick();
    check("mid_round_idx", 64'({dp_en, dp_round}), 64'h17);
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    wb_read(BASE + 32'h04, v);
    check("midreset_status", 64'(v), 64'd0);
    wb_read(BASE + 32'h1C, v);
    check("midreset_dout", 64'(v), 64'd0);
    wb_read(BASE, v);
    check("midreset_ctrl", 64'(v), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), res);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
